l2_cache: RTL and testbench

Second-level, set-associative, write-back cache. Responds to block-granular read/write requests from the L1 cache and fetches or evicts blocks over a block-wide main-memory handshake. It sits between the L1 cache's L2-side port and the memory model. It also keeps saturating-free (wrapping) hit/miss counters for the performance bench.

---
 rtl/l2_cache_if.sv | 35 +++
 rtl/l2_cache.sv | 261 ++++++++++++++++++++++++++
 tb/tb_l2_cache.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_cache_if.sv
// l2_cache_if: L1-side block request port plus block-wide memory handshake.
// Latency: none, wires only.
// Backpressure: L1 waits for l1_ready; memory holds mem_ready low until it completes.
// Ports (slave = cache view):
//   in : l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready
//   out: l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
interface l2_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16
) ();
  logic [ADDR_WIDTH-1:0]                 l1_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_data_in;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l1_data_out;
  logic                                  l1_read;
  logic                                  l1_write;
  logic                                  l1_ready;
  logic                                  l1_hit;
  logic [ADDR_WIDTH-1:0]                 mem_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in;
  logic                                  mem_read;
  logic                                  mem_write;
  logic                                  mem_ready;

  modport slave (
    input  l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
    output l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
  );

  modport master (
    output l1_addr, l1_data_in, l1_read, l1_write, mem_data_in, mem_ready,
    input  l1_data_out, l1_ready, l1_hit, mem_addr, mem_data_out, mem_read, mem_write
  );
endinterface

// File: rtl/l2_cache.sv
// l2_cache: set-associative write-back L2 with write-allocate, plus wrapping hit/miss counters.
// Latency: hit or clean write miss responds 1 cycle after accept; misses add writeback/fill time.
// Backpressure: requests are only accepted in IDLE; memory requests are level-held until mem_ready.
// Ports: clk, rst (async, active-high); bus (l2_cache_if.slave) carries the L1 and memory sides;
//   random_num selects the victim when a set is full; hit_count/miss_count count responses.
module l2_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  l2_cache_if.slave   bus,
  input  logic [3:0]  random_num,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int NUM_SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int OFF_W    = $clog2(BLOCK_SIZE);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [WAY_W-1:0] way_t;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  tag_t                tag_mem   [NUM_WAYS][NUM_SETS];
  block_t              data_mem  [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0] valid_mem [NUM_WAYS];
  logic [NUM_SETS-1:0] dirty_mem [NUM_WAYS];

  state_t state_q, state_d;

  // Latched request
  tag_t   rq_tag;
  idx_t   rq_idx;
  logic   rq_wr;
  block_t rq_data;
  way_t   rq_way;

  // Registered outputs and their next values
  logic                  ready_q, hit_q, mrd_q, mwr_q;
  block_t                dout_q, mdout_q;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic                  ready_d, hit_d, mrd_d, mwr_d, accept;
  block_t                dout_d, mdout_d;
  logic [ADDR_WIDTH-1:0] maddr_d;
  logic [31:0]           hcnt_d, mcnt_d;

  // Line install port
  logic   ins_en, ins_dirty;
  way_t   ins_way;
  idx_t   ins_idx;
  tag_t   ins_tag;
  block_t ins_blk;

  // Lookup on the incoming address
  idx_t   in_idx;
  tag_t   in_tag;
  logic   req_go, lk_hit, vict_dirty;
  way_t   hit_way, vict, rnd_way;
  logic   unused_bits;

  assign in_idx      = bus.l1_addr[OFF_W +: IDX_W];
  assign in_tag      = bus.l1_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_go      = bus.l1_read | bus.l1_write;
  assign rnd_way     = (NUM_WAYS == 1) ? '0 : way_t'(random_num[WAY_W-1:0]);
  assign unused_bits = ^{bus.l1_addr[OFF_W-1:0], random_num};

  always_comb begin
    lk_hit  = 1'b0;
    hit_way = '0;
    vict    = rnd_way;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!lk_hit && valid_mem[w][in_idx] && tag_mem[w][in_idx] == in_tag) begin
        lk_hit  = 1'b1;
        hit_way = way_t'(w);
      end
    end
    // Walk downwards so the lowest-index invalid way wins
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[w][in_idx]) vict = way_t'(w);
    end
  end

  assign vict_dirty = valid_mem[vict][in_idx] & dirty_mem[vict][in_idx];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_go && !lk_hit) begin
          if (vict_dirty)          state_d = WRITEBACK;
          else if (!bus.l1_write)  state_d = FILL;
        end
      end
      WRITEBACK: if (bus.mem_ready) state_d = rq_wr ? IDLE : FILL;
      FILL:      if (bus.mem_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    accept    = 1'b0;
    ready_d   = 1'b0;
    hit_d     = hit_q;
    dout_d    = dout_q;
    mrd_d     = mrd_q;
    mwr_d     = mwr_q;
    maddr_d   = maddr_q;
    mdout_d   = mdout_q;
    hcnt_d    = hit_count;
    mcnt_d    = miss_count;
    ins_en    = 1'b0;
    ins_dirty = 1'b0;
    ins_way   = rq_way;
    ins_idx   = rq_idx;
    ins_tag   = rq_tag;
    ins_blk   = rq_data;
    case (state_q)
      IDLE: begin
        if (req_go) begin
          accept = 1'b1;
          if (lk_hit) begin
            ready_d = 1'b1;
            hit_d   = 1'b1;
            hcnt_d  = hit_count + 32'd1;
            if (bus.l1_write) begin
              ins_en    = 1'b1;
              ins_dirty = 1'b1;
              ins_way   = hit_way;
              ins_idx   = in_idx;
              ins_tag   = in_tag;
              ins_blk   = bus.l1_data_in;
              dout_d    = bus.l1_data_in;
            end else begin
              dout_d = data_mem[hit_way][in_idx];
            end
          end else if (vict_dirty) begin
            mwr_d   = 1'b1;
            maddr_d = {tag_mem[vict][in_idx], in_idx, {OFF_W{1'b0}}};
            mdout_d = data_mem[vict][in_idx];
          end else if (!bus.l1_write) begin
            mrd_d   = 1'b1;
            maddr_d = {in_tag, in_idx, {OFF_W{1'b0}}};
          end else begin
            // Whole-block write: allocate without fetching
            ins_en    = 1'b1;
            ins_dirty = 1'b1;
            ins_way   = vict;
            ins_idx   = in_idx;
            ins_tag   = in_tag;
            ins_blk   = bus.l1_data_in;
            ready_d   = 1'b1;
            hit_d     = 1'b0;
            dout_d    = bus.l1_data_in;
            mcnt_d    = miss_count + 32'd1;
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ready) begin
          mwr_d = 1'b0;
          if (rq_wr) begin
            ins_en    = 1'b1;
            ins_dirty = 1'b1;
            ready_d   = 1'b1;
            hit_d     = 1'b0;
            dout_d    = rq_data;
            mcnt_d    = miss_count + 32'd1;
          end else begin
            mrd_d   = 1'b1;
            maddr_d = {rq_tag, rq_idx, {OFF_W{1'b0}}};
          end
        end
      end
      FILL: begin
        if (bus.mem_ready) begin
          ins_en  = 1'b1;
          ins_blk = bus.mem_data_in;
          ready_d = 1'b1;
          hit_d   = 1'b0;
          dout_d  = bus.mem_data_in;
          mcnt_d  = miss_count + 32'd1;
          mrd_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State, request latch and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rq_tag     <= '0;
      rq_idx     <= '0;
      rq_wr      <= 1'b0;
      rq_data    <= '0;
      rq_way     <= '0;
      ready_q    <= 1'b0;
      hit_q      <= 1'b0;
      mrd_q      <= 1'b0;
      mwr_q      <= 1'b0;
      maddr_q    <= '0;
      dout_q     <= '0;
      mdout_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_mem[w] <= '0;
        dirty_mem[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      hit_q      <= hit_d;
      mrd_q      <= mrd_d;
      mwr_q      <= mwr_d;
      maddr_q    <= maddr_d;
      dout_q     <= dout_d;
      mdout_q    <= mdout_d;
      hit_count  <= hcnt_d;
      miss_count <= mcnt_d;
      if (accept) begin
        rq_tag  <= in_tag;
        rq_idx  <= in_idx;
        rq_wr   <= bus.l1_write;
        rq_data <= bus.l1_data_in;
        rq_way  <= vict;
      end
      if (ins_en) begin
        valid_mem[ins_way][ins_idx] <= 1'b1;
        dirty_mem[ins_way][ins_idx] <= ins_dirty;
      end
    end
  end

  // Tag/data storage needs no reset; valid bits gate it
  always_ff @(posedge clk) begin
    if (ins_en) begin
      tag_mem[ins_way][ins_idx]  <= ins_tag;
      data_mem[ins_way][ins_idx] <= ins_blk;
    end
  end

  assign bus.l1_ready     = ready_q;
  assign bus.l1_hit       = hit_q;
  assign bus.l1_data_out  = dout_q;
  assign bus.mem_read     = mrd_q;
  assign bus.mem_write    = mwr_q;
  assign bus.mem_addr     = maddr_q;
  assign bus.mem_data_out = mdout_q;
endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: randomized and directed checks of l2_cache against a set/way reference model.
// Latency: n/a.
// Backpressure: a bench memory answers level-held requests after a programmable delay.
module tb_l2_cache;
  typedef logic [15:0][31:0] blk_t;

  logic        clk, rst;
  logic [3:0]  random_num;
  logic [31:0] hit_count, miss_count;

  l2_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BLOCK_SIZE(16)) bus ();

  l2_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CACHE_SIZE(4096), .BLOCK_SIZE(16), .NUM_WAYS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .random_num(random_num),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  bit          m_valid [64][4];
  bit          m_dirty [64][4];
  logic [21:0] m_tag   [64][4];
  blk_t        m_data  [64][4];
  logic [31:0] m_hits, m_miss;
  blk_t        ref_mem  [logic [31:0]];
  blk_t        phys_mem [logic [31:0]];

  function automatic blk_t pat(input logic [31:0] a);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = {a[29:0], 2'b00} + 32'(i);
    return b;
  endfunction

  function automatic blk_t ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  function automatic blk_t phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : pat(a);
  endfunction

  function automatic blk_t rnd_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_op(input logic [31:0] addr, input bit wr, input blk_t wdata, input logic [3:0] rnd,
                          output bit hit, output blk_t rdata, output bit wb, output logic [31:0] wb_addr,
                          output blk_t wb_data, output bit fill);
    int s, v;
    logic [21:0] t;
    s = int'(addr[9:4]);
    t = addr[31:10];
    hit = 0; wb = 0; fill = 0; wb_addr = '0; wb_data = '0; rdata = '0;
    for (int w = 0; w < 4; w++)
      if (!hit && m_valid[s][w] && m_tag[s][w] == t) begin
        hit = 1;
        if (wr) begin m_data[s][w] = wdata; m_dirty[s][w] = 1; end
        rdata = m_data[s][w];
      end
    if (hit) begin
      m_hits = m_hits + 1;
      return;
    end
    v = -1;
    for (int w = 0; w < 4; w++) if (v < 0 && !m_valid[s][w]) v = w;
    if (v < 0) v = int'(rnd[1:0]);
    if (m_valid[s][v] && m_dirty[s][v]) begin
      wb      = 1;
      wb_addr = {m_tag[s][v], addr[9:4], 4'b0000};
      wb_data = m_data[s][v];
      ref_mem[wb_addr] = wb_data;
    end
    m_valid[s][v] = 1;
    m_tag[s][v]   = t;
    if (wr) begin
      m_data[s][v]  = wdata;
      m_dirty[s][v] = 1;
      rdata = wdata;
    end else begin
      fill = 1;
      m_data[s][v]  = ref_rd({addr[31:4], 4'b0000});
      m_dirty[s][v] = 0;
      rdata = m_data[s][v];
    end
    m_miss = m_miss + 1;
  endtask

  // ---------------- bench memory and monitors ----------------
  int          mem_lat = 2;
  int          lat_cnt = 0;
  int          wb_cnt = 0, fill_cnt = 0, ev_seq = 0, wb_seq = 0, fill_seq = 0;
  logic [31:0] last_wb_addr = '0, last_fill_addr = '0;
  blk_t        last_wb_data = '0;
  int          ready_pulses = 0;
  bit          overlap = 0;

  initial begin
    bus.mem_ready   = 1'b0;
    bus.mem_data_in = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (rst) lat_cnt = 0;
      else if (bus.mem_read || bus.mem_write) begin
        if (lat_cnt >= mem_lat) begin
          bus.mem_ready = 1'b1;
          lat_cnt = 0;
          ev_seq++;
          if (bus.mem_write) begin
            phys_mem[bus.mem_addr] = bus.mem_data_out;
            wb_cnt++;
            last_wb_addr = bus.mem_addr;
            last_wb_data = bus.mem_data_out;
            wb_seq = ev_seq;
          end else begin
            bus.mem_data_in = phys_rd(bus.mem_addr);
            fill_cnt++;
            last_fill_addr = bus.mem_addr;
            fill_seq = ev_seq;
          end
        end else lat_cnt++;
      end else lat_cnt = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.l1_ready) ready_pulses++;
      if (bus.mem_read && bus.mem_write) overlap = 1;
    end
  end

  // ---------------- stimulus driver ----------------
  task automatic do_req(input logic [31:0] addr, input bit rd, input bit wr, input blk_t wdata,
                        input logic [3:0] rnd, output bit got, output bit hit, output blk_t data,
                        output int cycles);
    @(negedge clk);
    bus.l1_addr = addr; bus.l1_read = rd; bus.l1_write = wr; bus.l1_data_in = wdata; random_num = rnd;
    @(negedge clk);
    bus.l1_read = 1'b0; bus.l1_write = 1'b0;
    got = 0; cycles = 0;
    while (!got && cycles < 200) begin
      if (bus.l1_ready) got = 1;
      else begin @(negedge clk); cycles++; end
    end
    hit  = bus.l1_hit;
    data = bus.l1_data_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({bus.l1_ready, bus.l1_hit, bus.mem_read, bus.mem_write} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got %b want 0000", {bus.l1_ready, bus.l1_hit, bus.mem_read, bus.mem_write}); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.l1_data_out !== '0 || bus.mem_data_out !== '0) begin errors++; $display("FAIL reset_data mem_addr %h want 0", bus.mem_addr); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h/%h want 0/0", hit_count, miss_count); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    bit got, hit, eh, ewb, ef; blk_t d, ed, ewd; logic [31:0] ewa; int cyc;
    mem_lat = 3;
    model_op(32'h40, 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h40, 1, 0, '0, 4'd0, got, hit, d, cyc);
    checks++; if (!got || hit !== 1'b0) begin errors++; $display("FAIL cold_miss got ready=%0d hit=%0d want 1/0", got, hit); end
    checks++; if (d[5] !== 32'h105 || d !== ed) begin errors++; $display("FAIL cold_data word5 %h want 00000105", d[5]); end
    checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL cold_miss_cnt got %0d want 1", miss_count); end
    model_op(32'h45, 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h45, 1, 0, '0, 4'd0, got, hit, d, cyc);
    checks++; if (!got || cyc != 0 || hit !== 1'b1) begin errors++; $display("FAIL cold_rehit got ready=%0d cyc=%0d hit=%0d want 1/0/1", got, cyc, hit); end
    checks++; if (hit_count !== 32'd1 || d !== ed) begin errors++; $display("FAIL cold_hit_cnt got %0d want 1", hit_count); end
  endtask

  task automatic test_write_evict();
    bit got, hit, eh, ewb, ef; blk_t d, ed, ewd, wd; logic [31:0] ewa; int cyc, wb0, f0;
    logic [31:0] fills [3];
    fills[0] = 32'h440; fills[1] = 32'h840; fills[2] = 32'hC40;
    for (int i = 0; i < 16; i++) wd[i] = 32'hA0 + 32'(i);
    model_op(32'h40, 1, wd, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h40, 0, 1, wd, 4'd0, got, hit, d, cyc);
    checks++; if (!got || cyc != 0 || hit !== 1'b1 || d !== wd) begin errors++; $display("FAIL wr_hit got ready=%0d cyc=%0d hit=%0d want 1/0/1", got, cyc, hit); end
    for (int k = 0; k < 3; k++) begin
      mem_lat = k;
      model_op(fills[k], 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
      do_req(fills[k], 1, 0, '0, 4'd0, got, hit, d, cyc);
      checks++; if (!got || hit !== eh || d !== ed) begin errors++; $display("FAIL set4_fill%0d got hit=%0d want %0d", k, hit, eh); end
    end
    wb0 = wb_cnt; f0 = fill_cnt;
    model_op(32'h1040, 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h1040, 1, 0, '0, 4'd0, got, hit, d, cyc);
    checks++; if (wb_cnt != wb0 + 1 || last_wb_addr !== 32'h40) begin errors++; $display("FAIL evict_wb_addr got n=%0d addr=%h want 1/00000040", wb_cnt - wb0, last_wb_addr); end
    checks++; if (last_wb_data !== wd || !ewb || ewd !== wd) begin errors++; $display("FAIL evict_wb_data word0 %h want 000000a0", last_wb_data[0]); end
    checks++; if (fill_cnt != f0 + 1 || last_fill_addr !== 32'h1040) begin errors++; $display("FAIL evict_fill_addr got %h want 00001040", last_fill_addr); end
    checks++; if (!(wb_seq < fill_seq) || overlap) begin errors++; $display("FAIL evict_order wb_seq=%0d fill_seq=%0d overlap=%0d", wb_seq, fill_seq, overlap); end
    checks++; if (!got || hit !== 1'b0 || d !== ed) begin errors++; $display("FAIL evict_resp got hit=%0d want 0", hit); end
  endtask

  task automatic test_clean_write_miss();
    bit got, hit, eh, ewb, ef; blk_t d, ed, ewd, wd; logic [31:0] ewa; int cyc, wb0, f0;
    wd = rnd_blk();
    wb0 = wb_cnt; f0 = fill_cnt;
    model_op(32'h2000, 1, wd, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h2000, 0, 1, wd, 4'd0, got, hit, d, cyc);
    checks++; if (!got || cyc != 0 || hit !== 1'b0) begin errors++; $display("FAIL cwm_resp got ready=%0d cyc=%0d hit=%0d want 1/0/0", got, cyc, hit); end
    checks++; if (wb_cnt != wb0 || fill_cnt != f0) begin errors++; $display("FAIL cwm_no_mem got wb=%0d fill=%0d want 0/0", wb_cnt - wb0, fill_cnt - f0); end
    model_op(32'h2000, 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h2000, 1, 0, '0, 4'd0, got, hit, d, cyc);
    checks++; if (!got || hit !== 1'b1 || d !== wd) begin errors++; $display("FAIL cwm_readback got hit=%0d word0=%h want 1/%h", hit, d[0], wd[0]); end
  endtask

  task automatic test_simultaneous();
    bit got, hit, eh, ewb, ef; blk_t d, ed, ewd, wd; logic [31:0] ewa; int cyc, p0, wb0, f0, n;
    wd = rnd_blk();
    wb0 = wb_cnt; f0 = fill_cnt;
    model_op(32'h80, 1, wd, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    p0 = ready_pulses;
    do_req(32'h80, 1, 1, wd, 4'd0, got, hit, d, cyc);
    repeat (3) @(negedge clk);
    checks++; if (ready_pulses != p0 + 1 || hit !== eh || cyc != 0) begin errors++; $display("FAIL rw_one_pulse got pulses=%0d hit=%0d want 1/%0d", ready_pulses - p0, hit, eh); end
    checks++; if (wb_cnt != wb0 || fill_cnt != f0) begin errors++; $display("FAIL rw_as_write got fill=%0d want 0", fill_cnt - f0); end
    // Request held during FILL must not get its own response
    mem_lat = 5;
    model_op(32'h3000, 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    p0 = ready_pulses;
    @(negedge clk);
    bus.l1_addr = 32'h3000; bus.l1_read = 1'b1; bus.l1_write = 1'b0;
    @(negedge clk);
    bus.l1_addr = 32'h80; bus.l1_write = 1'b1; bus.l1_data_in = ~wd;
    n = 0;
    while (!bus.l1_ready && n < 200) begin @(negedge clk); n++; end
    d = bus.l1_data_out;
    bus.l1_read = 1'b0; bus.l1_write = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ready_pulses != p0 + 1 || d !== ed) begin errors++; $display("FAIL fill_ignore got pulses=%0d want 1", ready_pulses - p0); end
    model_op(32'h80, 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h80, 1, 0, '0, 4'd0, got, hit, d, cyc);
    checks++; if (!got || hit !== 1'b1 || d !== wd) begin errors++; $display("FAIL fill_ignore_data got word0=%h want %h", d[0], wd[0]); end
  endtask

  task automatic test_reset_midfill();
    bit got, hit, eh, ewb, ef; blk_t d, ed, ewd; logic [31:0] ewa; int cyc, p0;
    mem_lat = 100000;
    @(negedge clk);
    bus.l1_addr = 32'h7010; bus.l1_read = 1'b1;
    @(negedge clk);
    bus.l1_read = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL midfill_req got mem_read=%b want 1", bus.mem_read); end
    p0 = ready_pulses;
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.l1_ready !== 1'b0) begin errors++; $display("FAIL midfill_drop got rd=%b wr=%b rdy=%b want 000", bus.mem_read, bus.mem_write, bus.l1_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_lat = 1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (ready_pulses != p0) begin errors++; $display("FAIL midfill_no_resp got pulses=%0d want 0", ready_pulses - p0); end
    model_op(32'h7010, 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h7010, 1, 0, '0, 4'd0, got, hit, d, cyc);
    checks++; if (!got || hit !== 1'b0 || d !== ed || miss_count !== m_miss) begin errors++; $display("FAIL midfill_remiss got hit=%0d miss_count=%0d want 0/%0d", hit, miss_count, m_miss); end
  endtask

  task automatic test_counter_wrap();
    bit got, hit, eh, ewb, ef; blk_t d, ed, ewd; logic [31:0] ewa, mc0; int cyc;
    @(negedge clk);
    force dut.hit_count = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count;
    m_hits = 32'hFFFF_FFFF;
    mc0 = miss_count;
    model_op(32'h7014, 0, '0, 4'd0, eh, ed, ewb, ewa, ewd, ef);
    do_req(32'h7014, 1, 0, '0, 4'd0, got, hit, d, cyc);
    checks++; if (!got || hit !== 1'b1 || hit_count !== 32'h0) begin errors++; $display("FAIL wrap_hit got hit=%0d hit_count=%h want 1/00000000", hit, hit_count); end
    checks++; if (miss_count !== mc0 || hit_count !== m_hits) begin errors++; $display("FAIL wrap_miss_cnt got %h want %h", miss_count, mc0); end
  endtask

  task automatic test_random();
    bit got, hit, eh, ewb, ef, rd, wr; blk_t d, ed, ewd, wd; logic [31:0] ewa, a; logic [3:0] rn; int cyc, wb0, f0;
    for (int n = 0; n < 250; n++) begin
      a  = {19'(0), 3'($urandom_range(0, 5)), 6'(10 + $urandom_range(0, 1)), 4'($urandom)};
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 7) == 0);
      rn = 4'($urandom);
      wd = rnd_blk();
      mem_lat = $urandom_range(0, 3);
      wb0 = wb_cnt; f0 = fill_cnt;
      model_op(a, wr, wd, rn, eh, ed, ewb, ewa, ewd, ef);
      do_req(a, rd, wr, wd, rn, got, hit, d, cyc);
      checks++; if (!got || hit !== eh) begin errors++; $display("FAIL rnd_hit op%0d addr=%h got ready=%0d hit=%0d want 1/%0d", n, a, got, hit, eh); end
      if (!wr || eh) begin
        checks++; if (d !== ed) begin errors++; $display("FAIL rnd_data op%0d addr=%h word0 %h want %h", n, a, d[0], ed[0]); end
      end
      checks++; if ((wb_cnt - wb0) != int'(ewb) || (fill_cnt - f0) != int'(ef)) begin errors++; $display("FAIL rnd_mem op%0d got wb=%0d fill=%0d want %0d/%0d", n, wb_cnt - wb0, fill_cnt - f0, ewb, ef); end
      if (ewb) begin
        checks++; if (last_wb_addr !== ewa || last_wb_data !== ewd) begin errors++; $display("FAIL rnd_wb op%0d addr %h want %h", n, last_wb_addr, ewa); end
      end
      if (ef) begin
        checks++; if (last_fill_addr !== {a[31:4], 4'b0000}) begin errors++; $display("FAIL rnd_fill op%0d addr %h want %h", n, last_fill_addr, {a[31:4], 4'b0000}); end
      end
      if (eh || (wr && !ewb)) begin
        checks++; if (cyc != 0) begin errors++; $display("FAIL rnd_latency op%0d got %0d want 0", n, cyc); end
      end
    end
    checks++; if (hit_count !== m_hits || miss_count !== m_miss) begin errors++; $display("FAIL rnd_counters got %0d/%0d want %0d/%0d", hit_count, miss_count, m_hits, m_miss); end
    checks++; if (overlap) begin errors++; $display("FAIL rnd_overlap got mem_read&mem_write want never"); end
  endtask

  initial begin
    rst = 1'b0;
    bus.l1_addr = '0; bus.l1_read = 1'b0; bus.l1_write = 1'b0; bus.l1_data_in = '0;
    random_num = 4'd0;
    #1 rst = 1'b1;
    test_reset();
    test_cold_read();
    test_write_evict();
    test_clean_write_miss();
    test_simultaneous();
    test_reset_midfill();
    test_counter_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
